// File: rtl/ra_stack_ctrl_if.sv
// Return-address stack bus: call/return commit events in, prediction and ra-register writes out.
// Latency: n/a (wires only); every response on this bus is registered inside the stack.
// Backpressure: none; events are commit-time facts and are always accepted.
//
// Signals (master = decode/branch unit side, slave = stack controller):
//   flush, call_valid, call_addr, ret_valid           master -> slave
//   pred_valid, pred_addr                             slave -> master (fetch redirect)
//   ra_wr_en, ra_wr_data                              slave -> master (ra register write port)
//   empty, full, overflow, underflow                  slave -> master (status)
interface ra_stack_ctrl_if #(
  parameter int N = 32
);
  logic         flush;
  logic         call_valid;
  logic [N-1:0] call_addr;
  logic         ret_valid;
  logic         pred_valid;
  logic [N-1:0] pred_addr;
  logic         ra_wr_en;
  logic [N-1:0] ra_wr_data;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  modport master (
    output flush, call_valid, call_addr, ret_valid,
    input  pred_valid, pred_addr, ra_wr_en, ra_wr_data,
    input  empty, full, overflow, underflow
  );

  modport slave (
    input  flush, call_valid, call_addr, ret_valid,
    output pred_valid, pred_addr, ra_wr_en, ra_wr_data,
    output empty, full, overflow, underflow
  );
endinterface

// File: rtl/ra_stack_ctrl.sv
// Circular return-address stack: pushes on calls, pops on returns, predicts return targets, writes ra.
// Latency: 1 cycle; every response appears on the cycle after the sampling edge.
// Backpressure: none; a push on a full stack overwrites the oldest entry, a pop on empty flags underflow.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    ra_stack_ctrl_if.slave (flush/call/ret in; prediction, ra write and status out)
module ra_stack_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  ra_stack_ctrl_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Occupancy state mirrors count so the event decode doesn't need wide compares.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } occ_e;

  occ_e             st_q, st_d;
  logic [N-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [N-1:0]     mem_wdat;

  logic             pred_vld_q, pred_vld_d;
  logic [N-1:0]     pred_addr_q, pred_addr_d;
  logic             ra_wr_en_q, ra_wr_en_d;
  logic [N-1:0]     ra_wr_dat_q, ra_wr_dat_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Next-state and output decode. Priority: flush > call+ret > call > ret.
  always_comb begin
    tos_d       = tos_q;
    cnt_d       = cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = tos_q;
    mem_wdat    = bus.call_addr;
    pred_vld_d  = 1'b0;
    pred_addr_d = pred_addr_q;
    ra_wr_en_d  = 1'b0;
    ra_wr_dat_d = ra_wr_dat_q;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;

    if (bus.flush) begin
      // Contents are left in place; only the bookkeeping is cleared.
      tos_d = '0;
      cnt_d = '0;
    end else if (bus.call_valid && bus.ret_valid) begin
      // Tail call: the returning frame is replaced by the new one in place.
      ra_wr_en_d  = 1'b1;
      ra_wr_dat_d = bus.call_addr;
      mem_we      = 1'b1;
      mem_waddr   = tos_q;
      if (st_q == S_EMPTY) begin
        cnt_d = CNT_ONE;
        unf_d = 1'b1;
      end else begin
        pred_addr_d = mem[tos_q];
        pred_vld_d  = 1'b1;
      end
    end else if (bus.call_valid) begin
      tos_d       = tos_q + PTR_ONE;
      mem_we      = 1'b1;
      mem_waddr   = tos_q + PTR_ONE;
      ra_wr_en_d  = 1'b1;
      ra_wr_dat_d = bus.call_addr;
      // When full the write lands on the oldest slot, so count saturates.
      if (st_q == S_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (bus.ret_valid) begin
      if (st_q == S_EMPTY) begin
        unf_d = 1'b1;
      end else begin
        pred_addr_d = mem[tos_q];
        pred_vld_d  = 1'b1;
        tos_d       = tos_q - PTR_ONE;
        cnt_d       = cnt_q - CNT_ONE;
      end
    end

    if (cnt_d == '0) begin
      st_d = S_EMPTY;
    end else if (cnt_d == CNT_FULL) begin
      st_d = S_FULL;
    end else begin
      st_d = S_ACTIVE;
    end

    empty_d = (st_d == S_EMPTY);
    full_d  = (st_d == S_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= S_EMPTY;
      tos_q       <= '0;
      cnt_q       <= '0;
      pred_vld_q  <= 1'b0;
      pred_addr_q <= '0;
      ra_wr_en_q  <= 1'b0;
      ra_wr_dat_q <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      tos_q       <= tos_d;
      cnt_q       <= cnt_d;
      pred_vld_q  <= pred_vld_d;
      pred_addr_q <= pred_addr_d;
      ra_wr_en_q  <= ra_wr_en_d;
      ra_wr_dat_q <= ra_wr_dat_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  assign bus.pred_valid = pred_vld_q;
  assign bus.pred_addr  = pred_addr_q;
  assign bus.ra_wr_en   = ra_wr_en_q;
  assign bus.ra_wr_data = ra_wr_dat_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;

endmodule

// File: tb/tb_ra_stack_ctrl.sv
// Directed bench for ra_stack_ctrl (DEPTH=4, N=32) with hand-computed expectations.
// Latency: outputs sampled 1 time unit after the edge that registers each event.
// Backpressure: none exercised; the stack always accepts events.
module tb_ra_stack_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ra_stack_ctrl_if #(.N(32)) bus ();

  ra_stack_ctrl #(
    .N     (32),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Each event task drives its inputs, lets one edge sample them, then returns
  // 1 time unit after that edge with the inputs back to idle.
  task automatic cycle();
    @(posedge clk);
    #1;
    bus.flush      = 1'b0;
    bus.call_valid = 1'b0;
    bus.ret_valid  = 1'b0;
    bus.call_addr  = '0;
  endtask

  task automatic do_idle();
    cycle();
  endtask

  task automatic do_call(input logic [31:0] a);
    bus.call_valid = 1'b1;
    bus.call_addr  = a;
    cycle();
  endtask

  task automatic do_ret();
    bus.ret_valid = 1'b1;
    cycle();
  endtask

  task automatic do_both(input logic [31:0] a);
    bus.call_valid = 1'b1;
    bus.ret_valid  = 1'b1;
    bus.call_addr  = a;
    cycle();
  endtask

  task automatic do_flush_call(input logic [31:0] a);
    bus.flush      = 1'b1;
    bus.call_valid = 1'b1;
    bus.call_addr  = a;
    cycle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},  bus.empty,      32'd1);
    chk({tag, "_full"},   bus.full,       32'd0);
    chk({tag, "_pvld"},   bus.pred_valid, 32'd0);
    chk({tag, "_paddr"},  bus.pred_addr,  32'd0);
    chk({tag, "_raen"},   bus.ra_wr_en,   32'd0);
    chk({tag, "_radat"},  bus.ra_wr_data, 32'd0);
    chk({tag, "_ovf"},    bus.overflow,   32'd0);
    chk({tag, "_unf"},    bus.underflow,  32'd0);
  endtask

  logic [31:0] pops3 [3];
  logic [31:0] pops4 [4];

  initial begin
    checks         = 0;
    errors         = 0;
    bus.flush      = 1'b0;
    bus.call_valid = 1'b0;
    bus.ret_valid  = 1'b0;
    bus.call_addr  = '0;
    reset          = 1'b0;

    // 1. reset and idle
    #12;
    chk_reset_vals("rst");
    #11 reset = 1'b1;
    do_idle();
    do_idle();
    chk_reset_vals("idle");

    // 2. three pushes, three pops
    do_call(32'h100);
    chk("t2_raen", bus.ra_wr_en, 32'd1);
    chk("t2_radat", bus.ra_wr_data, 32'h100);
    chk("t2_empty1", bus.empty, 32'd0);
    do_call(32'h200);
    do_call(32'h300);
    chk("t2_radat3", bus.ra_wr_data, 32'h300);
    chk("t2_full3", bus.full, 32'd0);
    pops3 = '{32'h300, 32'h200, 32'h100};
    for (int i = 0; i < 3; i++) begin
      do_ret();
      chk($sformatf("t2_pop%0d_addr", i), bus.pred_addr, pops3[i]);
      chk($sformatf("t2_pop%0d_vld", i), bus.pred_valid, 32'd1);
      chk($sformatf("t2_pop%0d_raen", i), bus.ra_wr_en, 32'd0);
    end
    chk("t2_empty_end", bus.empty, 32'd1);
    do_idle();
    chk("t2_vld_pulse", bus.pred_valid, 32'd0);
    chk("t2_addr_hold", bus.pred_addr, 32'h100);

    // 3. overflow wrap
    do_call(32'h10);
    do_call(32'h20);
    do_call(32'h30);
    chk("t3_full3", bus.full, 32'd0);
    do_call(32'h40);
    chk("t3_full4", bus.full, 32'd1);
    chk("t3_ovf4", bus.overflow, 32'd0);
    do_call(32'h50);
    chk("t3_ovf5", bus.overflow, 32'd1);
    chk("t3_full5", bus.full, 32'd1);
    chk("t3_radat5", bus.ra_wr_data, 32'h50);
    do_idle();
    chk("t3_ovf_pulse", bus.overflow, 32'd0);
    pops4 = '{32'h50, 32'h40, 32'h30, 32'h20};
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk($sformatf("t3_pop%0d_addr", i), bus.pred_addr, pops4[i]);
      chk($sformatf("t3_pop%0d_vld", i), bus.pred_valid, 32'd1);
    end
    chk("t3_empty_end", bus.empty, 32'd1);
    chk("t3_full_end", bus.full, 32'd0);

    // 4. pop on empty
    do_ret();
    chk("t4_unf", bus.underflow, 32'd1);
    chk("t4_vld", bus.pred_valid, 32'd0);
    chk("t4_addr_hold", bus.pred_addr, 32'h20);
    chk("t4_empty", bus.empty, 32'd1);
    do_idle();
    chk("t4_unf_pulse", bus.underflow, 32'd0);

    // 5. tail call on a non-empty stack
    do_call(32'hA0);
    do_both(32'hB0);
    chk("t5_addr", bus.pred_addr, 32'hA0);
    chk("t5_vld", bus.pred_valid, 32'd1);
    chk("t5_raen", bus.ra_wr_en, 32'd1);
    chk("t5_radat", bus.ra_wr_data, 32'hB0);
    chk("t5_unf", bus.underflow, 32'd0);
    chk("t5_empty", bus.empty, 32'd0);
    do_ret();
    chk("t5_pop_addr", bus.pred_addr, 32'hB0);
    chk("t5_pop_vld", bus.pred_valid, 32'd1);
    chk("t5_pop_empty", bus.empty, 32'd1);

    // call+ret on an empty stack: push happens, underflow flagged
    do_both(32'hC0);
    chk("t5e_unf", bus.underflow, 32'd1);
    chk("t5e_vld", bus.pred_valid, 32'd0);
    chk("t5e_raen", bus.ra_wr_en, 32'd1);
    chk("t5e_addr_hold", bus.pred_addr, 32'hB0);
    chk("t5e_empty", bus.empty, 32'd0);
    do_ret();
    chk("t5e_pop_addr", bus.pred_addr, 32'hC0);
    chk("t5e_pop_empty", bus.empty, 32'd1);

    // 6. flush wins over a same-cycle call
    do_call(32'h1);
    do_call(32'h2);
    do_flush_call(32'h3);
    chk("t6_empty", bus.empty, 32'd1);
    chk("t6_raen", bus.ra_wr_en, 32'd0);
    chk("t6_radat_hold", bus.ra_wr_data, 32'h2);
    chk("t6_ovf", bus.overflow, 32'd0);
    do_ret();
    chk("t6_unf", bus.underflow, 32'd1);
    chk("t6_vld", bus.pred_valid, 32'd0);

    // asynchronous reset in the middle of a push
    bus.call_valid = 1'b1;
    bus.call_addr  = 32'h7;
    @(posedge clk);
    #2;
    chk("t7_raen_pre", bus.ra_wr_en, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("t7_async");
    bus.call_valid = 1'b0;
    bus.call_addr  = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    do_ret();
    chk("t7_post_unf", bus.underflow, 32'd1);
    chk("t7_post_addr", bus.pred_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
